ctrl_pipe_hazard: RTL and testbench

- Consumes the per-instruction control bundle produced by the ID-stage opcode decoder and carries it through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards and inserts bubbles.
- Resolves beq/bne in MEM and jumps in ID, generating the stall, flush and pc_src signals back to the fetch side.
- Sits between the decoder and the EX/MEM/WB datapath of the 5-stage MIPS core.

---
 rtl/ctrl_pipe_hazard_if.sv | 38 +++
 rtl/ctrl_pipe_hazard.sv | 151 +++++++++++++++
 tb/tb_ctrl_pipe_hazard.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pipe_hazard_if.sv
// Decoder-to-datapath control bundle for ctrl_pipe_hazard.
// The master side is the decoder/datapath; the slave side is the control pipeline.
interface ctrl_pipe_hazard_if #(
   parameter int REG_AW  = 5,
   parameter int ALUOP_W = 2
);
   logic               id_alu_src, id_reg_dst, id_branch1, id_branch2;
   logic               id_mem_write, id_mem_read, id_mem_to_reg, id_reg_write, id_jump;
   logic [ALUOP_W-1:0] id_alu_op;
   logic [REG_AW-1:0]  id_rs, id_rt, id_rd;
   logic               ex_zero;

   logic               ex_alu_src, ex_reg_dst;
   logic [ALUOP_W-1:0] ex_alu_op;
   logic [REG_AW-1:0]  ex_rs, ex_rt;
   logic               mem_mem_write, mem_mem_read;
   logic [REG_AW-1:0]  mem_wr_reg;
   logic               wb_reg_write, wb_mem_to_reg;
   logic [REG_AW-1:0]  wb_wr_reg;
   logic               stall, flush_ifid, pc_src;
   logic [1:0]         forward_a, forward_b;

   modport master (
      output id_alu_src, id_reg_dst, id_branch1, id_branch2, id_mem_write, id_mem_read,
             id_mem_to_reg, id_reg_write, id_jump, id_alu_op, id_rs, id_rt, id_rd, ex_zero,
      input  ex_alu_src, ex_reg_dst, ex_alu_op, ex_rs, ex_rt, mem_mem_write, mem_mem_read,
             mem_wr_reg, wb_reg_write, wb_mem_to_reg, wb_wr_reg, stall, flush_ifid, pc_src,
             forward_a, forward_b
   );

   modport slave (
      input  id_alu_src, id_reg_dst, id_branch1, id_branch2, id_mem_write, id_mem_read,
             id_mem_to_reg, id_reg_write, id_jump, id_alu_op, id_rs, id_rt, id_rd, ex_zero,
      output ex_alu_src, ex_reg_dst, ex_alu_op, ex_rs, ex_rt, mem_mem_write, mem_mem_read,
             mem_wr_reg, wb_reg_write, wb_mem_to_reg, wb_wr_reg, stall, flush_ifid, pc_src,
             forward_a, forward_b
   );
endinterface

// File: rtl/ctrl_pipe_hazard.sv
// MIPS 5-stage control pipeline (ID/EX, EX/MEM, MEM/WB) with hazard unit; CTRL_FWD_EN enables EX forwarding.
// Latency: one cycle per stage; stall, flush_ifid, pc_src and forward_* are combinational from pipeline state.
// Backpressure: RAW/load-use holds PC and IF/ID and bubbles ID/EX; a taken branch bubbles ID/EX and EX/MEM.
module ctrl_pipe_hazard #(
   parameter int REG_AW  = 5,
   parameter int ALUOP_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   ctrl_pipe_hazard_if.slave bus
);
   typedef logic [REG_AW-1:0] reg_t;

   typedef struct packed {
      logic               aluSrc;
      logic               regDst;
      logic [ALUOP_W-1:0] aluOp;
      logic               branch1;
      logic               branch2;
      logic               memWrite;
      logic               memRead;
      logic               memToReg;
      logic               regWrite;
      reg_t               rs;
      reg_t               rt;
      reg_t               rd;
   } idex_t;

   typedef struct packed {
      logic zero;
      logic branch1;
      logic branch2;
      logic memWrite;
      logic memRead;
      logic memToReg;
      logic regWrite;
      reg_t wrReg;
   } exmem_t;

   typedef struct packed {
      logic regWrite;
      logic memToReg;
      reg_t wrReg;
   } memwb_t;

   idex_t  idex, idIn;
   exmem_t exmem, exIn;
   memwb_t memwb;
   logic   pcSrc, loadUse, haz, stallInt;

   // Register 0 is hard-wired, so it never creates a dependency.
   function automatic logic srcHit(input reg_t dst, input reg_t rs, input reg_t rt);
      return (dst != '0) && ((dst == rs) || (dst == rt));
   endfunction

   always_comb begin
      idIn          = '0;
      idIn.aluSrc   = bus.id_alu_src;
      idIn.regDst   = bus.id_reg_dst;
      idIn.aluOp    = bus.id_alu_op;
      idIn.branch1  = bus.id_branch1;
      idIn.branch2  = bus.id_branch2;
      idIn.memWrite = bus.id_mem_write;
      idIn.memRead  = bus.id_mem_read;
      idIn.memToReg = bus.id_mem_to_reg;
      idIn.regWrite = bus.id_reg_write;
      idIn.rs       = bus.id_rs;
      idIn.rt       = bus.id_rt;
      idIn.rd       = bus.id_rd;
   end

   always_comb begin
      exIn          = '0;
      exIn.zero     = bus.ex_zero;
      exIn.branch1  = idex.branch1;
      exIn.branch2  = idex.branch2;
      exIn.memWrite = idex.memWrite;
      exIn.memRead  = idex.memRead;
      exIn.memToReg = idex.memToReg;
      exIn.regWrite = idex.regWrite;
      exIn.wrReg    = idex.regDst ? idex.rd : idex.rt;
   end

   always_comb begin
      pcSrc   = (exmem.branch1 & exmem.zero) | (exmem.branch2 & ~exmem.zero);
      loadUse = idex.memRead & srcHit(idex.rt, bus.id_rs, bus.id_rt);
`ifdef CTRL_FWD_EN
      haz     = loadUse;
`else
      // Without forwarding the consumer waits until every in-flight producer has written back.
      haz     = loadUse
              | (idex.regWrite  & srcHit(exIn.wrReg,  bus.id_rs, bus.id_rt))
              | (exmem.regWrite & srcHit(exmem.wrReg, bus.id_rs, bus.id_rt))
              | (memwb.regWrite & srcHit(memwb.wrReg, bus.id_rs, bus.id_rt));
`endif
      stallInt = haz & ~pcSrc;
   end

`ifdef CTRL_FWD_EN
   always_comb begin
      bus.forward_a = 2'b00;
      bus.forward_b = 2'b00;
      if (exmem.regWrite && (exmem.wrReg != '0) && (exmem.wrReg == idex.rs))
         bus.forward_a = 2'b10;
      else if (memwb.regWrite && (memwb.wrReg != '0) && (memwb.wrReg == idex.rs))
         bus.forward_a = 2'b01;
      if (exmem.regWrite && (exmem.wrReg != '0) && (exmem.wrReg == idex.rt))
         bus.forward_b = 2'b10;
      else if (memwb.regWrite && (memwb.wrReg != '0) && (memwb.wrReg == idex.rt))
         bus.forward_b = 2'b01;
   end
`else
   assign bus.forward_a = 2'b00;
   assign bus.forward_b = 2'b00;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         idex  <= '0;
         exmem <= '0;
         memwb <= '0;
      end else begin
         memwb.regWrite <= exmem.regWrite;
         memwb.memToReg <= exmem.memToReg;
         memwb.wrReg    <= exmem.wrReg;
         if (pcSrc) begin
            idex  <= '0;
            exmem <= '0;
         end else begin
            idex  <= stallInt ? '0 : idIn;
            exmem <= exIn;
         end
      end
   end

   assign bus.ex_alu_src    = idex.aluSrc;
   assign bus.ex_reg_dst    = idex.regDst;
   assign bus.ex_alu_op     = idex.aluOp;
   assign bus.ex_rs         = idex.rs;
   assign bus.ex_rt         = idex.rt;
   assign bus.mem_mem_write = exmem.memWrite;
   assign bus.mem_mem_read  = exmem.memRead;
   assign bus.mem_wr_reg    = exmem.wrReg;
   assign bus.wb_reg_write  = memwb.regWrite;
   assign bus.wb_mem_to_reg = memwb.memToReg;
   assign bus.wb_wr_reg     = memwb.wrReg;
   assign bus.stall         = stallInt;
   assign bus.pc_src        = pcSrc;
   // A stalled jump holds off its flush until the stall releases.
   assign bus.flush_ifid    = pcSrc | (bus.id_jump & ~stallInt);
endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Scoreboard bench for ctrl_pipe_hazard: an instruction-level model predicts every output each cycle.
// Build with +define+CTRL_FWD_EN to exercise the forwarding variant.
module tb_ctrl_pipe_hazard;
   localparam int AW = 5;
   localparam int OW = 2;
   localparam int K_NOP = 0, K_R = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5, K_J = 6;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ctrl_pipe_hazard_if #(.REG_AW(AW), .ALUOP_W(OW)) bus ();
   ctrl_pipe_hazard #(.REG_AW(AW), .ALUOP_W(OW)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed {
      logic       aluSrc, regDst;
      logic [1:0] aluOp;
      logic       b1, b2, mw, mr, m2r, rw, jump;
      logic [4:0] rs, rt, rd;
   } instr_t;

   typedef struct {
      logic [4:0] exRs, exRt, memWr, wbWr;
      logic [1:0] exAluOp, fa, fb;
      logic       exAluSrc, exRegDst, memMw, memMr, wbRw, wbM2r, stall, flush, pcSrc;
      int         cyc;
   } exp_t;

   // Instructions resident in EX, MEM and WB; a bubble is an all-zero instruction.
   instr_t mEx, mMem, mWb;
   logic   mZero;
   logic   lastStall;
   logic   armed = 1'b0;
   int     cyc = 0;
   int     nCmp = 0;
   int     nBad = 0;
   exp_t   expQ[$];

   function automatic logic [4:0] dest(input instr_t i);
      return i.regDst ? i.rd : i.rt;
   endfunction

   function automatic logic reads(input instr_t id, input logic [4:0] r);
      return (r != 5'd0) && ((r == id.rs) || (r == id.rt));
   endfunction

`ifdef CTRL_FWD_EN
   function automatic logic [1:0] fwd(input logic [4:0] src, input instr_t m, input instr_t w);
      if (m.rw && dest(m) != 5'd0 && dest(m) == src) return 2'b10;
      if (w.rw && dest(w) != 5'd0 && dest(w) == src) return 2'b01;
      return 2'b00;
   endfunction
`endif

   function automatic instr_t mk(input int kind, input int rs, input int rt, input int rd);
      instr_t i;
      logic [4:0] a, b, c;
      a = rs[4:0];
      b = rt[4:0];
      c = rd[4:0];
      i = '0;
      i.rs = a;
      i.rt = b;
      i.rd = c;
      case (kind)
         K_R:     begin i.rw = 1; i.regDst = 1; i.aluOp = 2'd2; end
         K_LW:    begin i.aluSrc = 1; i.mr = 1; i.m2r = 1; i.rw = 1; end
         K_SW:    begin i.aluSrc = 1; i.mw = 1; end
         K_BEQ:   begin i.b1 = 1; i.aluOp = 2'd1; end
         K_BNE:   begin i.b2 = 1; i.aluOp = 2'd1; end
         K_J:     i.jump = 1;
         default: i = '0;
      endcase
      return i;
   endfunction

   function automatic instr_t rnd(input logic allowJump);
      instr_t i;
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 9) == 0) i = instr_t'(r[$bits(instr_t)-1:0]);
      else i = mk(int'($urandom_range(0, 6)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      if (!allowJump) i.jump = 1'b0;
      return i;
   endfunction

   task automatic chk(input string nm, input int c, input logic [7:0] act, input logic [7:0] want);
      nCmp++;
      if (act !== want) begin
         nBad++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, c, act, want);
      end
   endtask

   // One clock: drive ID, predict this cycle's outputs, then advance the model at the edge.
   task automatic step(input instr_t ins, input logic zero, input logic r);
      exp_t e;
      logic ps, hz, st;
      rst               = r;
      bus.id_alu_src    = ins.aluSrc;
      bus.id_reg_dst    = ins.regDst;
      bus.id_alu_op     = ins.aluOp;
      bus.id_branch1    = ins.b1;
      bus.id_branch2    = ins.b2;
      bus.id_mem_write  = ins.mw;
      bus.id_mem_read   = ins.mr;
      bus.id_mem_to_reg = ins.m2r;
      bus.id_reg_write  = ins.rw;
      bus.id_jump       = ins.jump;
      bus.id_rs         = ins.rs;
      bus.id_rt         = ins.rt;
      bus.id_rd         = ins.rd;
      bus.ex_zero       = zero;

      ps = (mMem.b1 && mZero) || (mMem.b2 && !mZero);
      hz = mEx.mr && reads(ins, mEx.rt);
`ifndef CTRL_FWD_EN
      hz = hz || (mEx.rw && reads(ins, dest(mEx))) || (mMem.rw && reads(ins, dest(mMem)))
              || (mWb.rw && reads(ins, dest(mWb)));
`endif
      st = hz && !ps;

      e.exAluSrc = mEx.aluSrc;
      e.exRegDst = mEx.regDst;
      e.exAluOp  = mEx.aluOp;
      e.exRs     = mEx.rs;
      e.exRt     = mEx.rt;
      e.memMw    = mMem.mw;
      e.memMr    = mMem.mr;
      e.memWr    = dest(mMem);
      e.wbRw     = mWb.rw;
      e.wbM2r    = mWb.m2r;
      e.wbWr     = dest(mWb);
      e.stall    = st;
      e.pcSrc    = ps;
      e.flush    = ps || (ins.jump && !st);
`ifdef CTRL_FWD_EN
      e.fa = fwd(mEx.rs, mMem, mWb);
      e.fb = fwd(mEx.rt, mMem, mWb);
`else
      e.fa = 2'b00;
      e.fb = 2'b00;
`endif
      e.cyc = cyc;
      if (armed) expQ.push_back(e);
      lastStall = st;

      @(posedge clk);
      if (r) begin
         mEx = '0; mMem = '0; mWb = '0; mZero = 1'b0;
      end else begin
         mWb = mMem;
         if (ps) begin
            mEx = '0; mMem = '0; mZero = 1'b0;
         end else begin
            mMem  = mEx;
            mZero = zero;
            mEx   = st ? '0 : ins;
         end
      end
      cyc++;
      #2;
   endtask

   // Present an instruction and hold it in ID for as long as the pipeline stalls it.
   task automatic issue(input instr_t ins, input logic zero);
      int n;
      n = 0;
      do begin
         step(ins, zero, 1'b0);
         n++;
      end while (lastStall && n < 20);
      if (lastStall) begin
         nCmp++;
         nBad++;
         $display("FAIL stall_bound cycle=%0d got=stuck expected=release within 20", cyc);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step(mk(K_NOP, 0, 0, 0), 1'b0, 1'b0);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (expQ.size() > 0) begin
            e = expQ.pop_front();
            chk("ex_alu_src",    e.cyc, 8'(bus.ex_alu_src),    8'(e.exAluSrc));
            chk("ex_reg_dst",    e.cyc, 8'(bus.ex_reg_dst),    8'(e.exRegDst));
            chk("ex_alu_op",     e.cyc, 8'(bus.ex_alu_op),     8'(e.exAluOp));
            chk("ex_rs",         e.cyc, 8'(bus.ex_rs),         8'(e.exRs));
            chk("ex_rt",         e.cyc, 8'(bus.ex_rt),         8'(e.exRt));
            chk("mem_mem_write", e.cyc, 8'(bus.mem_mem_write), 8'(e.memMw));
            chk("mem_mem_read",  e.cyc, 8'(bus.mem_mem_read),  8'(e.memMr));
            chk("mem_wr_reg",    e.cyc, 8'(bus.mem_wr_reg),    8'(e.memWr));
            chk("wb_reg_write",  e.cyc, 8'(bus.wb_reg_write),  8'(e.wbRw));
            chk("wb_mem_to_reg", e.cyc, 8'(bus.wb_mem_to_reg), 8'(e.wbM2r));
            chk("wb_wr_reg",     e.cyc, 8'(bus.wb_wr_reg),     8'(e.wbWr));
            chk("stall",         e.cyc, 8'(bus.stall),         8'(e.stall));
            chk("flush_ifid",    e.cyc, 8'(bus.flush_ifid),    8'(e.flush));
            chk("pc_src",        e.cyc, 8'(bus.pc_src),        8'(e.pcSrc));
            chk("forward_a",     e.cyc, 8'(bus.forward_a),     8'(e.fa));
            chk("forward_b",     e.cyc, 8'(bus.forward_b),     8'(e.fb));
         end
      end
   end

   initial begin
      mEx = '0; mMem = '0; mWb = '0; mZero = 1'b0; lastStall = 1'b0;
      // First reset edge brings the DUT out of X; checking starts once it has cleared.
      step(rnd(1'b0), 1'b0, 1'b1);
      armed = 1'b1;
      repeat (2) step(rnd(1'b0), 1'($urandom_range(0, 1)), 1'b1);

      // R-type rd=5 reaches write-back three edges after release.
      issue(mk(K_R, 1, 2, 5), 1'b0);
      idle(5);

      // Load-use: lw rt=8 followed by a consumer of r8.
      issue(mk(K_LW, 9, 8, 0), 1'b0);
      issue(mk(K_R, 8, 2, 6), 1'b0);
      idle(5);

      // beq taken with zero=1 while the branch sits in EX.
      issue(mk(K_R, 1, 2, 5), 1'b0);
      issue(mk(K_BEQ, 1, 2, 0), 1'b0);
      step(mk(K_NOP, 0, 0, 0), 1'b1, 1'b0);
      idle(5);

      // bne: not taken on zero=1, taken on zero=0.
      issue(mk(K_BNE, 3, 4, 0), 1'b0);
      step(mk(K_NOP, 0, 0, 0), 1'b1, 1'b0);
      idle(4);
      issue(mk(K_BNE, 3, 4, 0), 1'b0);
      step(mk(K_NOP, 0, 0, 0), 1'b0, 1'b0);
      idle(5);

      // Jump whose rt field collides with a load destination.
      issue(mk(K_LW, 1, 3, 0), 1'b0);
      issue(mk(K_J, 0, 3, 0), 1'b0);
      idle(5);

      // Producer/consumer distances 1 and 2, and a write to r0.
      issue(mk(K_R, 1, 2, 4), 1'b0);
      issue(mk(K_R, 4, 4, 7), 1'b0);
      idle(5);
      issue(mk(K_R, 1, 2, 4), 1'b0);
      issue(mk(K_NOP, 0, 0, 0), 1'b0);
      issue(mk(K_R, 4, 4, 7), 1'b0);
      idle(5);
      issue(mk(K_R, 1, 2, 0), 1'b0);
      issue(mk(K_R, 0, 0, 7), 1'b0);
      idle(5);

      // Reset during a load-use stall and during a branch flush.
      issue(mk(K_LW, 9, 8, 0), 1'b0);
      step(mk(K_R, 8, 2, 6), 1'b0, 1'b1);
      idle(3);
      issue(mk(K_BEQ, 1, 1, 0), 1'b0);
      step(mk(K_NOP, 0, 0, 0), 1'b1, 1'b0);
      step(mk(K_NOP, 0, 0, 0), 1'b0, 1'b1);
      idle(3);

      repeat (3000) step(rnd(1'b1), 1'($urandom_range(0, 1)), ($urandom_range(0, 199) == 0));
      idle(4);

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end
endmodule
